// File: rtl/cbus_rr_arbiter.sv
// N:1 CBus arbiter. One requester owns the downstream port for a whole burst and
// then releases it; priority is round-robin or fixed (lowest index wins).

package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic        err;
        logic [31:0] rdata;
    } cbus_resp_t;

endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int unsigned  NUM_INPUTS = 2,
    parameter bit           RR_ENABLE  = 1'b1,
    localparam int unsigned IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0] iresps,
    output cbus_req_t                   oreq,
    input  cbus_resp_t                  oresp,
    output logic                        grant_valid,
    output logic [IDX_W-1:0]            grant_idx
);

    localparam logic [IDX_W:0]   NumW    = (IDX_W + 1)'(NUM_INPUTS);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_INPUTS - 1);

    if (NUM_INPUTS == 0 || NUM_INPUTS > 16) begin : g_bad_param
        $error("cbus_rr_arbiter: NUM_INPUTS must be in 1..16");
    end

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_d;

    logic [IDX_W-1:0] search_base;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] next_ptr;
    logic             done;

    // Circular search starting at search_base; fixed priority simply starts at 0.
    always_comb begin
        search_base = RR_ENABLE ? rr_ptr : '0;
        sel_found   = 1'b0;
        sel_idx     = '0;
        cand        = '0;
        for (int unsigned off = 0; off < NUM_INPUTS; off++) begin
            cand = {1'b0, search_base} + (IDX_W + 1)'(off);
            if (cand >= NumW) begin
                cand = cand - NumW;
            end
            if (!sel_found && ireqs[cand[IDX_W-1:0]].valid) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign done     = (state_q == StBusy) && oresp.ready && oresp.last;
    assign next_ptr = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d = StBusy;
                    grant_d = sel_idx;
                end
            end
            StBusy: begin
                // Only the final beat releases the grant; owner's valid is not consulted.
                if (done) begin
                    state_d  = StIdle;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            rr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_ptr  <= rr_ptr_d;
        end
    end

    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state_q == StBusy) begin
            oreq            = ireqs[grant_q];
            iresps[grant_q] = oresp;
        end
    end

    assign grant_valid = (state_q == StBusy);
    assign grant_idx   = grant_q;

    a_idle_idx_zero: assert property (@(posedge clk) disable iff (reset)
        !grant_valid |-> (grant_idx == '0));

    a_single_resp: assert property (@(posedge clk) disable iff (reset)
        !grant_valid |-> (iresps == '0) && (oreq == '0));

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter: a vector table across N=4 round-robin and fixed-priority
// instances, plus hand sequences for bursts, reset mid-burst and the single-input case.

module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cbus_resp_t oresp;

    cbus_req_t  [1:0] ireqs2;
    cbus_resp_t [1:0] iresps2;
    cbus_req_t        oreq2;
    logic             gv2;
    logic [0:0]       gi2;

    cbus_req_t  [3:0] ireqs4;
    cbus_resp_t [3:0] iresps4r, iresps4f;
    cbus_req_t        oreq4r, oreq4f;
    logic             gv4r, gv4f;
    logic [1:0]       gi4r, gi4f;

    cbus_req_t  [2:0] ireqs3;
    cbus_resp_t [2:0] iresps3;
    cbus_req_t        oreq3;
    logic             gv3;
    logic [1:0]       gi3;

    cbus_req_t  [0:0] ireqs1;
    cbus_resp_t [0:0] iresps1;
    cbus_req_t        oreq1;
    logic             gv1;
    logic [0:0]       gi1;

    cbus_rr_arbiter #(.NUM_INPUTS(2), .RR_ENABLE(1'b1)) u2 (
        .clk(clk), .reset(reset), .ireqs(ireqs2), .iresps(iresps2), .oreq(oreq2),
        .oresp(oresp), .grant_valid(gv2), .grant_idx(gi2));

    cbus_rr_arbiter #(.NUM_INPUTS(4), .RR_ENABLE(1'b1)) u4r (
        .clk(clk), .reset(reset), .ireqs(ireqs4), .iresps(iresps4r), .oreq(oreq4r),
        .oresp(oresp), .grant_valid(gv4r), .grant_idx(gi4r));

    cbus_rr_arbiter #(.NUM_INPUTS(4), .RR_ENABLE(1'b0)) u4f (
        .clk(clk), .reset(reset), .ireqs(ireqs4), .iresps(iresps4f), .oreq(oreq4f),
        .oresp(oresp), .grant_valid(gv4f), .grant_idx(gi4f));

    cbus_rr_arbiter #(.NUM_INPUTS(3), .RR_ENABLE(1'b1)) u3 (
        .clk(clk), .reset(reset), .ireqs(ireqs3), .iresps(iresps3), .oreq(oreq3),
        .oresp(oresp), .grant_valid(gv3), .grant_idx(gi3));

    cbus_rr_arbiter #(.NUM_INPUTS(1), .RR_ENABLE(1'b1)) u1 (
        .clk(clk), .reset(reset), .ireqs(ireqs1), .iresps(iresps1), .oreq(oreq1),
        .oresp(oresp), .grant_valid(gv1), .grant_idx(gi1));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  mask;
        int unsigned exp_rr;
        int unsigned exp_fx;
    } vec_t;

    typedef struct {
        int unsigned rr;
        int unsigned fx;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cbus_req_t mk_req(input int unsigned id);
        cbus_req_t r;
        r       = '0;
        r.valid = 1'b1;
        r.write = id[0];
        r.addr  = 32'h1000 + id * 16;
        r.wdata = 32'hA5A5_0000 | id;
        r.wstrb = 4'hF;
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst, input logic [31:0] d);
        cbus_resp_t r;
        r       = '0;
        r.ready = rdy;
        r.last  = lst;
        r.rdata = d;
        return r;
    endfunction

    task automatic clear_all();
        ireqs2 = '0;
        ireqs4 = '0;
        ireqs3 = '0;
        ireqs1 = '0;
        oresp  = '0;
    endtask

    // Leaves reset low; the next tick is the first arbitration edge.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        check("rst_gv", 128'({gv2, gv4r, gv4f, gv3, gv1}), 128'(0));
        check("rst_gi", 128'({gi2, gi4r, gi4f, gi3, gi1}), 128'(0));
        check("rst_oreq", 128'(oreq2 | oreq4r | oreq4f | oreq3 | oreq1), 128'(0));
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned waited;
        exp_t        e;

        vecs[0] = '{4'b1111, 0, 0};
        vecs[1] = '{4'b1111, 1, 0};
        vecs[2] = '{4'b0001, 0, 0};
        vecs[3] = '{4'b1010, 1, 1};
        vecs[4] = '{4'b1010, 3, 1};
        vecs[5] = '{4'b1010, 1, 1};
        vecs[6] = '{4'b0100, 2, 2};
        vecs[7] = '{4'b1001, 3, 0};
        vecs[8] = '{4'b0110, 1, 1};
        vecs[9] = '{4'b1111, 2, 0};

        reset = 1'b1;
        clear_all();

        // N=2 RR: both valid from reset -> 0, idle, 1, idle, 0.
        ireqs2[0] = mk_req(0);
        ireqs2[1] = mk_req(1);
        do_reset();
        tick();
        check("a_gv0", 128'(gv2), 128'(1));
        check("a_gi0", 128'(gi2), 128'(0));
        check("a_oreq0", 128'(oreq2), 128'(mk_req(0)));
        oresp = mk_resp(1'b1, 1'b1, 32'hD0);
        #1;
        check("a_resp0", 128'(iresps2[0]), 128'(mk_resp(1'b1, 1'b1, 32'hD0)));
        check("a_resp1_zero", 128'(iresps2[1]), 128'(0));
        tick();
        oresp = '0;
        check("a_gap1", 128'(gv2), 128'(0));
        check("a_gap1_oreq", 128'(oreq2), 128'(0));
        tick();
        check("a_gi1", 128'({gv2, gi2}), 128'(2'b11));
        check("a_oreq1", 128'(oreq2), 128'(mk_req(1)));
        oresp = mk_resp(1'b1, 1'b1, 32'hD1);
        tick();
        oresp = '0;
        check("a_gap2", 128'(gv2), 128'(0));
        tick();
        check("a_gi0_again", 128'({gv2, gi2}), 128'(2'b10));
        oresp = mk_resp(1'b1, 1'b1, 32'hD2);
        tick();
        oresp = '0;
        clear_all();

        // N=4 table: round-robin and fixed priority see the same requests.
        do_reset();
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 4; i++) begin
                ireqs4[i] = vecs[v].mask[i] ? mk_req(i + 4 * v) : '0;
            end
            sb.push_back('{vecs[v].exp_rr, vecs[v].exp_fx});
            waited = 0;
            do begin
                tick();
                waited++;
            end while (!gv4r && waited < 4);
            e = sb.pop_front();
            check($sformatf("tbl%0d_latency", v), 128'(waited), 128'(1));
            check($sformatf("tbl%0d_rr_idx", v), 128'(gi4r), 128'(e.rr));
            check($sformatf("tbl%0d_fx_idx", v), 128'(gi4f), 128'(e.fx));
            check($sformatf("tbl%0d_rr_oreq", v), 128'(oreq4r), 128'(mk_req(e.rr + 4 * v)));
            check($sformatf("tbl%0d_fx_oreq", v), 128'(oreq4f), 128'(mk_req(e.fx + 4 * v)));
            oresp = mk_resp(1'b1, 1'b1, 32'(v));
            #1;
            check($sformatf("tbl%0d_fx_resp", v), 128'(iresps4f[e.fx]),
                  128'(mk_resp(1'b1, 1'b1, 32'(v))));
            tick();
            oresp  = '0;
            ireqs4 = '0;
            check($sformatf("tbl%0d_release", v), 128'({gv4r, gv4f}), 128'(0));
        end
        clear_all();

        // N=4 RR: 4-beat burst on req2 only, then pointer must sit at 3.
        do_reset();
        ireqs4[2] = mk_req(2);
        tick();
        check("b_gi", 128'({gv4r, gi4r}), 128'(3'b110));
        for (int b = 1; b <= 4; b++) begin
            oresp = mk_resp(1'b1, (b == 4), 32'hB0 + 32'(b));
            #1;
            check($sformatf("b_beat%0d_gi", b), 128'({gv4r, gi4r}), 128'(3'b110));
            check($sformatf("b_beat%0d_others", b),
                  128'(iresps4r[0] | iresps4r[1] | iresps4r[3]), 128'(0));
            check($sformatf("b_beat%0d_owner", b), 128'(iresps4r[2]),
                  128'(mk_resp(1'b1, (b == 4), 32'hB0 + 32'(b))));
            check($sformatf("b_beat%0d_oreq", b), 128'(oreq4r), 128'(mk_req(2)));
            tick();
        end
        oresp = '0;
        check("b_release", 128'(gv4r), 128'(0));
        for (int i = 0; i < 4; i++) ireqs4[i] = mk_req(i);
        tick();
        check("b_rr_ptr3", 128'({gv4r, gi4r}), 128'(3'b111));
        oresp = mk_resp(1'b1, 1'b1, 32'h0);
        tick();
        clear_all();

        // N=3 RR: req1 arrives mid-burst, owner 0 held until last.
        do_reset();
        ireqs3[0] = mk_req(0);
        tick();
        check("c_gi0", 128'({gv3, gi3}), 128'(3'b100));
        oresp = mk_resp(1'b1, 1'b0, 32'hC1);
        tick();
        ireqs3[1] = mk_req(1);
        oresp = mk_resp(1'b1, 1'b0, 32'hC2);
        #1;
        check("c_mid_gi", 128'({gv3, gi3}), 128'(3'b100));
        check("c_mid_resp1", 128'(iresps3[1]), 128'(0));
        tick();
        check("c_hold_gi", 128'({gv3, gi3}), 128'(3'b100));
        oresp = mk_resp(1'b1, 1'b1, 32'hC3);
        tick();
        oresp = '0;
        check("c_gap", 128'(gv3), 128'(0));
        tick();
        check("c_next_gi1", 128'({gv3, gi3}), 128'(3'b101));
        oresp = mk_resp(1'b1, 1'b1, 32'hC4);
        tick();
        clear_all();

        // N=2: reset on beat 2 of owner 1's burst abandons it; pointer returns to 0.
        ireqs2[0] = mk_req(0);
        do_reset();
        tick();
        check("d_gi0", 128'({gv2, gi2}), 128'(2'b10));
        oresp = mk_resp(1'b1, 1'b1, 32'hE0);
        tick();
        oresp     = '0;
        ireqs2[1] = mk_req(1);
        tick();
        check("d_gi1", 128'({gv2, gi2}), 128'(2'b11));
        oresp = mk_resp(1'b1, 1'b0, 32'hE1);
        tick();
        oresp = mk_resp(1'b1, 1'b0, 32'hE2);
        reset = 1'b1;
        tick();
        check("d_rst_gv", 128'({gv2, gi2}), 128'(0));
        check("d_rst_oreq_valid", 128'(oreq2.valid), 128'(0));
        check("d_rst_resps", 128'(iresps2), 128'(0));
        oresp = '0;
        reset = 1'b0;
        tick();
        check("d_after_rst_gi0", 128'({gv2, gi2}), 128'(2'b10));
        oresp = mk_resp(1'b1, 1'b1, 32'hE3);
        tick();
        clear_all();

        // N=1: pass-through with one bubble between transactions.
        ireqs1[0] = mk_req(7);
        do_reset();
        tick();
        check("e_gv", 128'({gv1, gi1}), 128'(2'b10));
        check("e_oreq_c1", 128'(oreq1), 128'(mk_req(7)));
        tick();
        check("e_oreq_c2", 128'(oreq1), 128'(mk_req(7)));
        tick();
        oresp = mk_resp(1'b1, 1'b1, 32'hF3);
        #1;
        check("e_oreq_c3", 128'(oreq1), 128'(mk_req(7)));
        check("e_resp", 128'(iresps1[0]), 128'(mk_resp(1'b1, 1'b1, 32'hF3)));
        tick();
        oresp = '0;
        check("e_gap", 128'(gv1), 128'(0));
        check("e_gap_oreq", 128'(oreq1), 128'(0));
        tick();
        check("e_regrant", 128'({gv1, gi1}), 128'(2'b10));
        oresp = mk_resp(1'b1, 1'b1, 32'hF4);
        tick();
        clear_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
